muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 56 +++++
 rtl/muldiv_seq.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM encoding,
// iteration count, SrcOut select codes and an operand magnitude helper.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [5:0] ITER = 6'd32;

   localparam logic [2:0] SRC_LO     = 3'd0;
   localparam logic [2:0] SRC_HI     = 3'd1;
   localparam logic [2:0] SRC_LT     = 3'd2;
   localparam logic [2:0] SRC_RESULT = 3'd3;
   localparam logic [2:0] SRC_OR     = 3'd4;
   localparam logic [2:0] SRC_SHIFT  = 3'd5;

   function automatic logic [31:0] mag32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the radix-2 Booth multiplier and, when MULDIV_SEQ_DIV_EN is
// defined, one restoring-division step; purely combinational.
module muldiv_step (
   input  logic [32:0] i_acc,
   input  logic [31:0] i_q,
   input  logic        i_qm1,
   input  logic [31:0] i_m,
`ifdef MULDIV_SEQ_DIV_EN
   output logic [31:0] o_div_rem,
   output logic [31:0] o_div_q,
`endif
   output logic [32:0] o_booth_acc,
   output logic [31:0] o_booth_q,
   output logic        o_booth_qm1
);

   logic [32:0] w_m_ext;
   logic [32:0] w_sum;

   assign w_m_ext = {i_m[31], i_m};

   // Accumulator is one bit wider than the operand so adding or subtracting
   // 0x80000000 can never overflow before the arithmetic shift.
   always_comb begin
      w_sum = i_acc;
      case ({i_q[0], i_qm1})
         2'b01:   w_sum = i_acc + w_m_ext;
         2'b10:   w_sum = i_acc - w_m_ext;
         default: w_sum = i_acc;
      endcase
   end

   assign o_booth_acc = {w_sum[32], w_sum[32:1]};
   assign o_booth_q   = {w_sum[0], i_q[31:1]};
   assign o_booth_qm1 = i_q[0];

`ifdef MULDIV_SEQ_DIV_EN
   logic [32:0] w_shift;
   logic [32:0] w_diff;

   // Partial remainder stays below the divisor, so the trial difference fits
   // in 33 bits and its top bit is the restore decision.
   assign w_shift = {i_acc[31:0], i_q[31]};
   assign w_diff  = w_shift - {1'b0, i_m};

   always_comb begin
      o_div_rem = w_diff[31:0];
      o_div_q   = {i_q[30:0], 1'b1};
      if (w_diff[32]) begin
         o_div_rem = w_shift[31:0];
         o_div_q   = {i_q[30:0], 1'b0};
      end
   end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed 32x32 multiply / divide with Hi/Lo registers; 32 busy cycles then a done pulse.
// Divider is compiled in only when MULDIV_SEQ_DIV_EN is defined; otherwise start_div reports via div_zero.
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   state_t      r_state;
   state_t      w_state_nx;
   logic [5:0]  r_cnt;
   logic [32:0] r_acc;
   logic [31:0] r_q;
   logic        r_qm1;
   logic [31:0] r_m;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_dz;

   logic        w_busy;
   logic        w_can_start;
   logic        w_go_mult;
   logic        w_go_div;
   logic        w_last;
   logic [32:0] w_booth_acc;
   logic [31:0] w_booth_q;
   logic        w_booth_qm1;

`ifdef MULDIV_SEQ_DIV_EN
   logic        r_q_neg;
   logic        r_r_neg;
   logic        w_b_zero;
   logic [31:0] w_div_rem;
   logic [31:0] w_div_q;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;

   assign w_b_zero  = (b == 32'd0);
   assign w_quo_fix = r_q_neg ? (~w_div_q + 32'd1) : w_div_q;
   assign w_rem_fix = r_r_neg ? (~w_div_rem + 32'd1) : w_div_rem;
`endif

   assign w_busy      = (r_state == MULT) || (r_state == DIV);
   assign w_can_start = (r_state == IDLE) || (r_state == DONE);
   assign w_go_mult   = w_can_start && start_mult;
   assign w_go_div    = w_can_start && !start_mult && start_div;
   assign w_last      = (r_cnt == 6'd1);

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign busy     = w_busy;
   assign done     = (r_state == DONE);
   assign div_zero = r_dz;

   muldiv_step u_step (
      .i_acc       (r_acc),
      .i_q         (r_q),
      .i_qm1       (r_qm1),
      .i_m         (r_m),
`ifdef MULDIV_SEQ_DIV_EN
      .o_div_rem   (w_div_rem),
      .o_div_q     (w_div_q),
`endif
      .o_booth_acc (w_booth_acc),
      .o_booth_q   (w_booth_q),
      .o_booth_qm1 (w_booth_qm1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_go_mult) begin
               w_state_nx = MULT;
            end else if (w_go_div) begin
`ifdef MULDIV_SEQ_DIV_EN
               w_state_nx = w_b_zero ? DONE : DIV;
`else
               w_state_nx = DONE;
`endif
            end else begin
               w_state_nx = IDLE;
            end
         end
         MULT: begin
            if (w_last) w_state_nx = DONE;
         end
`ifdef MULDIV_SEQ_DIV_EN
         DIV: begin
            if (w_last) w_state_nx = DONE;
         end
`endif
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_qm1   <= 1'b0;
         r_m     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_dz    <= 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
`endif
      end else begin
         r_dz <= 1'b0;
         // An MT write accepted with a start lands now; the result overwrites it later.
         if (!w_busy) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
         end
         case (r_state)
            IDLE, DONE: begin
               if (w_go_mult) begin
                  r_acc <= '0;
                  r_q   <= a;
                  r_qm1 <= 1'b0;
                  r_m   <= b;
                  r_cnt <= ITER;
               end else if (w_go_div) begin
`ifdef MULDIV_SEQ_DIV_EN
                  if (w_b_zero) begin
                     r_dz <= 1'b1;
                  end else begin
                     r_acc   <= '0;
                     r_q     <= mag32(a);
                     r_qm1   <= 1'b0;
                     r_m     <= mag32(b);
                     r_cnt   <= ITER;
                     r_q_neg <= a[31] ^ b[31];
                     r_r_neg <= a[31];
                  end
`else
                  r_dz <= 1'b1;
`endif
               end
            end
            MULT: begin
               r_acc <= w_booth_acc;
               r_q   <= w_booth_q;
               r_qm1 <= w_booth_qm1;
               r_cnt <= r_cnt - 6'd1;
               if (w_last) begin
                  r_hi <= w_booth_acc[31:0];
                  r_lo <= w_booth_q;
               end
            end
`ifdef MULDIV_SEQ_DIV_EN
            DIV: begin
               r_acc <= {1'b0, w_div_rem};
               r_q   <= w_div_q;
               r_cnt <= r_cnt - 6'd1;
               if (w_last) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of multiply/divide vectors plus
// hand-written sequences for divide-by-zero, ignored inputs, reset and dual start.
module tb_muldiv_seq;

   localparam int OP_MUL  = 0;
   localparam int OP_DIV  = 1;
   localparam int OP_BOTH = 2;
   localparam int NV      = 10;

   typedef struct {
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_mult = 1'b0;
   logic        start_div = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   vec_t        vt [NV];

   muldiv_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_mult (start_mult),
      .start_div  (start_div),
      .a          (a),
      .b          (b),
      .hi_we      (hi_we),
      .lo_we      (lo_we),
      .wdata      (wdata),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Entered and left at #1 after a rising edge.
   task automatic run_op(input string name, input int op, input logic [31:0] ta,
                         input logic [31:0] tb_, input int poke, input int exp_lat,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
      int cyc;
      int nbusy;
      a = ta;
      b = tb_;
      start_mult = (op == OP_MUL) || (op == OP_BOTH);
      start_div  = (op == OP_DIV) || (op == OP_BOTH);
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a = 32'hA5A5_A5A5;
      b = 32'h5A5A_5A5A;
      cyc   = 1;
      nbusy = 0;
      while (!done && cyc < 40) begin
         if (busy) nbusy++;
         if (cyc == poke) begin
            start_div = 1'b1;
            lo_we     = 1'b1;
            wdata     = 32'hDEAD_BEEF;
         end
         @(posedge clk);
         #1;
         start_div = 1'b0;
         lo_we     = 1'b0;
         cyc++;
      end
      chk({name, " latency"}, cyc, exp_lat);
      chk({name, " busy_cycles"}, nbusy, exp_lat - 1);
      chk({name, " hi"}, hi, ehi);
      chk({name, " lo"}, lo, elo);
      chk({name, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
      @(posedge clk);
      #1;
      chk({name, " done_pulse_end"}, {31'd0, done}, 32'd0);
      m_hi = ehi;
      m_lo = elo;
   endtask

   initial begin
      int          lat;
      logic [31:0] ehi;
      logic [31:0] elo;
      logic        edz;

      vt[0] = '{OP_MUL, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vt[1] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vt[2] = '{OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vt[3] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vt[4] = '{OP_DIV, 32'd100,        32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
      vt[5] = '{OP_MUL, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
      vt[6] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      vt[7] = '{OP_DIV, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
      vt[8] = '{OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vt[9] = '{OP_MUL, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000};

      repeat (3) @(posedge clk);
      #1;
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset div_zero", {31'd0, div_zero}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         lat = 33;
         ehi = vt[i].hi;
         elo = vt[i].lo;
         edz = 1'b0;
`ifndef MULDIV_SEQ_DIV_EN
         if (vt[i].op == OP_DIV) begin
            lat = 1;
            ehi = m_hi;
            elo = m_lo;
            edz = 1'b1;
         end
`endif
         run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, -1, lat, ehi, elo, edz);
      end

      // MTHI then divide by zero: completes next cycle, Hi/Lo untouched.
      hi_we = 1'b1;
      wdata = 32'h0000_1234;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      chk("mthi", hi, 32'h0000_1234);
      m_hi = 32'h0000_1234;
      run_op("divzero", OP_DIV, 32'd5, 32'd0, -1, 1, m_hi, m_lo, 1'b1);

      // Reset at cycle 15 of a long operation, then starts held during reset are ignored.
`ifdef MULDIV_SEQ_DIV_EN
      a = 32'hFFFF_FFF9;
      b = 32'd2;
      start_div = 1'b1;
`else
      a = 32'd9;
      b = 32'd9;
      start_mult = 1'b1;
`endif
      @(posedge clk);
      #1;
      start_div  = 1'b0;
      start_mult = 1'b0;
      for (int c = 1; c < 15; c++) begin
         @(posedge clk);
         #1;
      end
      chk("midop busy_before_reset", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midop hi", hi, 32'd0);
      chk("midop lo", lo, 32'd0);
      chk("midop busy", {31'd0, busy}, 32'd0);
      start_mult = 1'b1;
      a = 32'd3;
      b = 32'd4;
      @(posedge clk);
      #1;
      chk("start_in_reset busy", {31'd0, busy}, 32'd0);
      start_mult = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("after_reset", OP_MUL, 32'd3, 32'd4, -1, 33, 32'd0, 32'd12, 1'b0);

      // start_div and lo_we pulsed at cycle 10 must not disturb the multiply.
      run_op("ignored", OP_MUL, 32'd5, 32'd6, 10, 33, 32'd0, 32'd30, 1'b0);

      // Both starts together: multiply wins.
      run_op("both", OP_BOTH, 32'h8000_0000, 32'hFFFF_FFFF, -1, 33,
             32'h0000_0000, 32'h8000_0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
